// File: rtl/edge_pipe_pkg.sv
// Shared definitions for the edge pipeline: frame geometry defaults, the
// statistics FSM state type and the bounding-box record.
package edge_pipe_pkg;

    localparam int IMG_W_DEF   = 10;
    localparam int IMG_H_DEF   = 10;
    localparam int DATA_W_DEF  = 8;
    localparam int COORD_W_DEF = 4;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [COORD_W_DEF-1:0] x_min;
        logic [COORD_W_DEF-1:0] x_max;
        logic [COORD_W_DEF-1:0] y_min;
        logic [COORD_W_DEF-1:0] y_max;
    } bbox_t;

    // Grow a box to include (col,row); the first edge pixel seeds all four bounds.
    function automatic bbox_t bbox_merge(
        input bbox_t                  box,
        input logic [COORD_W_DEF-1:0] col,
        input logic [COORD_W_DEF-1:0] row,
        input logic                   seed
    );
        bbox_t res;
        res = box;
        if (seed) begin
            res.x_min = col;
            res.x_max = col;
            res.y_min = row;
            res.y_max = row;
        end else begin
            if (col < box.x_min) res.x_min = col;
            if (col > box.x_max) res.x_max = col;
            if (row < box.y_min) res.y_min = row;
            if (row > box.y_max) res.y_max = row;
        end
        return res;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row position of the current pixel in raster order. A clear forces the
// current position to (0,0), so a pixel arriving with the clear is the frame's first.
module raster_counter #(
    parameter int IMG_W   = 10,
    parameter int IMG_H   = 10,
    parameter int COORD_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    input  logic               clear,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               first_px,
    output logic               last_px
);

    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);

    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] col_eff, row_eff;

    always_comb begin
        col_eff  = clear ? '0 : col_q;
        row_eff  = clear ? '0 : row_q;
        first_px = (col_eff == '0) && (row_eff == '0);
        last_px  = (col_eff == LAST_COL) && (row_eff == LAST_ROW);
        col_d    = col_eff;
        row_d    = row_eff;
        if (advance) begin
            if (col_eff == LAST_COL) begin
                col_d = '0;
                row_d = (row_eff == LAST_ROW) ? '0 : row_eff + COORD_W'(1);
            end else begin
                col_d = col_eff + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col = col_eff;
    assign row = row_eff;

endmodule

// File: rtl/edge_bbox_stats.sv
// Binarizes the edge-magnitude stream and publishes per-frame edge count and
// bounding box with a one-cycle stats_valid pulse.
module edge_bbox_stats
    import edge_pipe_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  edge_input,
    input  logic               edge_input_valid,
    input  logic [DATA_W-1:0]  threshold,
    input  logic               frame_start,
    output logic               bin_output,
    output logic               bin_output_valid,
    output logic [CNT_W-1:0]   edge_count,
    output logic [COORD_W-1:0] bbox_x_min,
    output logic [COORD_W-1:0] bbox_x_max,
    output logic [COORD_W-1:0] bbox_y_min,
    output logic [COORD_W-1:0] bbox_y_max,
    output logic               bbox_valid,
    output logic               stats_valid,
    output logic               busy
);

    logic [COORD_W-1:0] col, row;
    logic               first_px, last_px;

    raster_counter #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .COORD_W (COORD_W)
    ) u_raster (
        .clk      (clk),
        .reset    (reset),
        .advance  (edge_input_valid),
        .clear    (frame_start),
        .col      (col),
        .row      (row),
        .first_px (first_px),
        .last_px  (last_px)
    );

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  thr_q, thr_d;
    logic [DATA_W-1:0]  thr_eff;
    logic               is_edge;
    logic               acc_clear;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               acc_any_q, acc_any_d;
    bbox_t              acc_box_q, acc_box_d;
    logic               bin_q, bin_d;
    logic               bin_valid_q, bin_valid_d;
    logic [CNT_W-1:0]   edge_count_q, edge_count_d;
    bbox_t              pub_box_q, pub_box_d;
    logic               bbox_valid_q, bbox_valid_d;

    always_comb begin
        thr_eff     = first_px ? threshold : thr_q;
        thr_d       = (edge_input_valid && first_px) ? threshold : thr_q;
        is_edge     = edge_input_valid && (edge_input >= thr_eff);
        bin_d       = is_edge;
        bin_valid_d = edge_input_valid;

        // The DONE cycle and frame_start both hand the next pixel fresh accumulators.
        acc_clear = frame_start || (state_q == ST_DONE);
        acc_cnt_d = acc_clear ? '0 : acc_cnt_q;
        acc_any_d = acc_clear ? 1'b0 : acc_any_q;
        acc_box_d = acc_clear ? '0 : acc_box_q;
        if (is_edge) begin
            if (acc_cnt_d != '1) acc_cnt_d = acc_cnt_d + CNT_W'(1);
            acc_box_d = bbox_merge(acc_box_d, col, row, !acc_any_d);
            acc_any_d = 1'b1;
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (edge_input_valid) state_d = last_px ? ST_DONE : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (edge_input_valid && last_px) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (edge_input_valid) state_d = last_px ? ST_DONE : ST_ACCUM;
                else                  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (frame_start) begin
            if (edge_input_valid) state_d = last_px ? ST_DONE : ST_ACCUM;
            else                  state_d = ST_IDLE;
        end

        // Publish registers load on entry to DONE so they are visible alongside stats_valid.
        edge_count_d = edge_count_q;
        pub_box_d    = pub_box_q;
        bbox_valid_d = bbox_valid_q;
        if (state_d == ST_DONE) begin
            edge_count_d = acc_cnt_d;
            bbox_valid_d = acc_any_d;
            pub_box_d    = acc_any_d ? acc_box_d : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            thr_q        <= '0;
            acc_cnt_q    <= '0;
            acc_any_q    <= 1'b0;
            acc_box_q    <= '0;
            bin_q        <= 1'b0;
            bin_valid_q  <= 1'b0;
            edge_count_q <= '0;
            pub_box_q    <= '0;
            bbox_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            thr_q        <= thr_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_any_q    <= acc_any_d;
            acc_box_q    <= acc_box_d;
            bin_q        <= bin_d;
            bin_valid_q  <= bin_valid_d;
            edge_count_q <= edge_count_d;
            pub_box_q    <= pub_box_d;
            bbox_valid_q <= bbox_valid_d;
        end
    end

    assign bin_output       = bin_q;
    assign bin_output_valid = bin_valid_q;
    assign edge_count       = edge_count_q;
    assign bbox_x_min       = pub_box_q.x_min;
    assign bbox_x_max       = pub_box_q.x_max;
    assign bbox_y_min       = pub_box_q.y_min;
    assign bbox_y_max       = pub_box_q.y_max;
    assign bbox_valid       = bbox_valid_q;
    assign stats_valid      = (state_q == ST_DONE);
    assign busy             = (state_q == ST_ACCUM);

endmodule
